// File: rtl/mux_4to1_pkg.sv
// mux_4to1_pkg: shared select codes and helpers for the mux_4to1 slice.
//   SEL_D0..SEL_D3 : {s1,s0} codes that pick d0..d3
//   is_onehot4()   : legality check for the optional one-hot select
package mux_4to1_pkg;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;
    localparam logic [1:0] SEL_D3 = 2'b11;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/mux_4to1_comb.sv
// mux_4to1_comb: pure combinational 4:1 selector.
//   d0..d3 : WIDTH-bit data sources
//   sel    : 2-bit code, d0..d3 for 00..11 (default build)
//   sel_oh : one-hot select, bit i picks d<i> (MUX_4TO1_ONEHOT_SEL_EN build)
//   y      : selected data
// Macro MUX_4TO1_ONEHOT_SEL_EN swaps the binary select for a one-hot one;
// zero or multi-hot selects give y = 0.
module mux_4to1_comb
    import mux_4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
`ifdef MUX_4TO1_ONEHOT_SEL_EN
    input  logic [3:0]       sel_oh,
`else
    input  logic [1:0]       sel,
`endif
    output logic [WIDTH-1:0] y
);

`ifdef MUX_4TO1_ONEHOT_SEL_EN
    always_comb begin
        case (sel_oh)
            4'b0001: y = d0;
            4'b0010: y = d1;
            4'b0100: y = d2;
            4'b1000: y = d3;
            default: y = '0;
        endcase
    end
`else
    // The default arm is reachable only with X/Z on sel: it propagates X
    // in simulation and is a don't-care for synthesis.
    always_comb begin
        case (sel)
            SEL_D0:  y = d0;
            SEL_D1:  y = d1;
            SEL_D2:  y = d2;
            SEL_D3:  y = d3;
            default: y = {WIDTH{1'bx}};
        endcase
    end
`endif

endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 selector with combinational output and a one-cycle
// registered copy qualified by a valid flag.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   d0..d3    : WIDTH-bit sources
//   s1, s0    : select code {s1,s0}
//   in_valid  : capture the current selection at the next edge
//   y         : combinational selected data
//   y_q       : registered selected data (holds when in_valid=0)
//   out_valid : y_q was captured at the last edge
// Macro MUX_4TO1_ONEHOT_SEL_EN adds sel_oh[3:0] (replaces s1/s0, which are
// then ignored) and sel_err, a one-cycle flag after a captured beat whose
// sel_oh was not one-hot.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             s1,
    input  logic             s0,
`ifdef MUX_4TO1_ONEHOT_SEL_EN
    input  logic [3:0]       sel_oh,
    output logic             sel_err,
`endif
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid
);

`ifdef MUX_4TO1_ONEHOT_SEL_EN
    // s1/s0 stay on the port list for pin compatibility but play no part.
    logic unused_sel;
    assign unused_sel = s1 ^ s0;
`endif

    mux_4to1_comb #(.WIDTH(WIDTH)) u_comb (
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
`ifdef MUX_4TO1_ONEHOT_SEL_EN
        .sel_oh (sel_oh),
`else
        .sel    ({s1, s0}),
`endif
        .y      (y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            out_valid <= 1'b0;
`ifdef MUX_4TO1_ONEHOT_SEL_EN
            sel_err   <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                y_q <= y;
`ifdef MUX_4TO1_ONEHOT_SEL_EN
            sel_err   <= in_valid && !is_onehot4(sel_oh);
`endif
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench for mux_4to1 (WIDTH=8 and WIDTH=1 instances
// sharing select/control). The driver computes expected post-edge state from
// a simple array-indexed model and queues it; a monitor pops one entry per
// rising edge and compares.
module tb_mux_4to1;

    logic       clk = 1'b0;
    logic       rst, s1, s0, in_valid;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] y, y_q;
    logic       out_valid;
    logic       y1, y_q1, out_valid1;
    logic [3:0] sel_oh;
`ifdef MUX_4TO1_ONEHOT_SEL_EN
    logic       sel_err, sel_err1;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] yq;
        logic       ov;
        logic       yq1;
        logic       err;
    } exp_t;
    exp_t q[$];

    // model state after the most recent edge
    logic [7:0] m_yq  = '0;
    logic       m_yq1 = 1'b0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .s1(s1), .s0(s0),
`ifdef MUX_4TO1_ONEHOT_SEL_EN
        .sel_oh(sel_oh), .sel_err(sel_err),
`endif
        .in_valid(in_valid), .y(y), .y_q(y_q), .out_valid(out_valid)
    );

    mux_4to1 #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .d0(1'b0), .d1(1'b1), .d2(1'b0), .d3(1'b1),
        .s1(s1), .s0(s0),
`ifdef MUX_4TO1_ONEHOT_SEL_EN
        .sel_oh(sel_oh), .sel_err(sel_err1),
`endif
        .in_valid(in_valid), .y(y1), .y_q(y_q1), .out_valid(out_valid1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one beat (call while clk is low), check y, queue post-edge state.
    task automatic step(input logic r, input logic iv, input logic [1:0] sel,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e,
                        input logic [3:0] oh);
        logic [7:0] dd [4];
        logic       w1 [4];
        logic [7:0] ref_y;
        logic       ref_y1;
        logic       bad;
        exp_t       ex;
        dd = '{a, b, c, e};
        w1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef MUX_4TO1_ONEHOT_SEL_EN
        bad = ($countones(oh) != 1);
        ref_y  = bad ? 8'h00 : dd[$clog2(oh)];
        ref_y1 = bad ? 1'b0  : w1[$clog2(oh)];
`else
        bad = 1'b0;
        ref_y  = dd[sel];
        ref_y1 = w1[sel];
`endif
        rst = r; in_valid = iv; s1 = sel[1]; s0 = sel[0];
        d0 = a; d1 = b; d2 = c; d3 = e; sel_oh = oh;
        if (r) begin
            m_yq = '0; m_yq1 = 1'b0;
        end else if (iv) begin
            m_yq = ref_y; m_yq1 = ref_y1;
        end
        ex.yq  = m_yq;
        ex.yq1 = m_yq1;
        ex.ov  = !r && iv;
        ex.err = !r && iv && bad;
        q.push_back(ex);
        #1;
        chk("y", y, ref_y);
        chk("y_w1", y1, ref_y1);
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                ex = q.pop_front();
                chk("y_q", y_q, ex.yq);
                chk("out_valid", out_valid, ex.ov);
                chk("y_q_w1", y_q1, ex.yq1);
                chk("out_valid_w1", out_valid1, ex.ov);
`ifdef MUX_4TO1_ONEHOT_SEL_EN
                chk("sel_err", sel_err, ex.err);
`endif
            end
        end
    end

    initial begin
        logic [1:0] sel;
        logic [3:0] oh;
        // reset with a valid beat pending: nothing captured
        step(1, 1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000);
        @(negedge clk); step(1, 1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000);
        // select sweep, capturing every cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step(0, 1, 2'(i), 8'h11, 8'h22, 8'h33, 8'h44, 4'(1 << i));
        end
        // mid-stream reset, then first post-reset edge captures 8'h44
        repeat (2) begin
            @(negedge clk); step(1, 1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000);
        end
        @(negedge clk); step(0, 1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000);
        // in_valid low while select toggles: y_q holds 44
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            step(0, 0, 2'(i), 8'h11, 8'h22, 8'h33, 8'h44, 4'(1 << i));
        end
        // d2 change with no edge: y follows at once, y_q holds
        @(negedge clk); step(0, 0, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100);
        d2 = 8'hA5;
        #1 chk("y_d2_change", y, 8'hA5);
        // the next valid edge captures the new value
        @(negedge clk); step(0, 1, 2'b10, 8'h11, 8'h22, 8'hA5, 8'h44, 4'b0100);
`ifdef MUX_4TO1_ONEHOT_SEL_EN
        // multi-hot captured: y=0, sel_err for one cycle
        @(negedge clk); step(0, 1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0110);
        @(negedge clk); step(0, 1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100);
        @(negedge clk); step(0, 1, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
`endif
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            sel = 2'($urandom_range(0, 3));
            oh  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << sel);
            @(negedge clk);
            step(($urandom_range(0, 24) == 0), 1'($urandom), sel,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), oh);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Parameterised 4:1 selector with a combinational output and a one-cycle registered output plus valid flag.
- Used wherever one of four equal-width sources is steered onto a shared datapath.
- Select is a 2-bit code {s1,s0}; d0..d3 map to codes 0..3.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- d0  input  WIDTH  data source, selected when {s1,s0}=2'b00
- d1  input  WIDTH  data source, selected when {s1,s0}=2'b01
- d2  input  WIDTH  data source, selected when {s1,s0}=2'b10
- d3  input  WIDTH  data source, selected when {s1,s0}=2'b11
- s1  input  1  select MSB
- s0  input  1  select LSB
- in_valid  input  1  qualifies the current select/data for capture
- y  output  WIDTH  combinational selected data
- y_q  output  WIDTH  registered selected data
- out_valid  output  1  y_q holds a captured value

Behaviour:
- Combinational path:
  - y = d0/d1/d2/d3 for {s1,s0} = 00/01/10/11.
  - Zero latency, purely combinational, unaffected by clk or rst.
- Unknown select: any X/Z on s1 or s0 drives y to all-X in simulation. Synthesis treats this as don't-care.
- Registered path:
  - On a rising clk with in_valid=1, y_q <= y (the same-cycle selection) and out_valid <= 1.
  - With in_valid=0, y_q holds and out_valid <= 0.
- Latency: y_q and out_valid reflect the inputs present at the prior rising edge (1 cycle).
- Reset:
  - rst=1 at a rising edge forces y_q=0 and out_valid=0. This overrides in_valid.
  - Reset mid-stream discards the pending capture. The first capture after reset is the first edge with rst=0 and in_valid=1.
- No back-pressure: every valid beat is captured and there is no ready signal.
- Simultaneous select and data change: both are sampled together at the edge, and no glitch filtering is performed.
- Width rule: all data ports are exactly WIDTH bits, with no extension or truncation inside the block.

Optional Feature:
- Macro: MUX_4TO1_ONEHOT_SEL_EN.
- When defined:
  - Adds input sel_oh[3:0] (one-hot), which replaces s1/s0 for selection. s1 and s0 remain present and are ignored.
  - A zero or multi-hot sel_oh drives y=0.
  - Adds output sel_err (registered, reset 0), set for one cycle after any captured beat whose sel_oh was not one-hot.
- When not defined: sel_oh and sel_err do not exist, and behaviour is exactly as specified above.

Decomposition:
- Package mux_4to1_pkg holds:
  - localparams SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_D3=2'b11
  - a function for the one-hot legality check
- One sub-module, mux_4to1_comb, contains the pure combinational selector (parameter WIDTH), instantiated once.
- The top level adds the capture register and valid flag.

Test Plan:
- WIDTH=1, d0=0 d1=1 d2=0 d3=1, hold each select for 10 ns → y=0 for 00, y=1 for 01, y=0 for 10, y=1 for 11.
- WIDTH=8, d0=8'h11 d1=8'h22 d2=8'h33 d3=8'h44, sweep select with in_valid=1 each cycle → y_q equals the previous cycle's y (11,22,33,44) and out_valid=1 from the second edge on.
- Assert rst for 2 cycles while in_valid=1 and select=11 → y_q=0 and out_valid=0 during reset. The first post-reset edge captures 8'h44.
- in_valid=0 for 3 cycles while select toggles → y follows select, y_q holds its last captured value, out_valid=0.
- Change d2 from 8'h33 to 8'hA5 while select=10, with no clock edge → y becomes 8'hA5 immediately and y_q is unchanged until the next valid edge.
- With MUX_4TO1_ONEHOT_SEL_EN defined:
  - sel_oh=4'b0100 → y=d2, sel_err stays 0.
  - sel_oh=4'b0110 captured → y=0 and sel_err=1 for exactly one cycle.
